// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Instruction encoder and program-memory writer. Packs
//               {addr_w, addr_b, addr_a, opcode} field bundles received over
//               a valid/ready stream into WORD_W-bit instruction words. Words
//               are written sequentially into a DEPTH-entry program memory,
//               which is exported as a packed array for the fetch stage.
//
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               start_i      - one-cycle pulse, begins a load at address 0
//               in_valid_i   - field bundle valid
//               in_ready_o   - loader accepts a bundle (registered, LOAD only)
//               in_last_i    - final instruction of the program
//               opcode_i     - instruction opcode
//               addr_a_i     - source A register address
//               addr_b_i     - source B register address
//               addr_w_i     - destination register address
//               mem_o        - packed program memory, fetch-side view
//               prog_len_o   - words written in current/last load (0..DEPTH)
//               done_o       - load complete
//               err_o        - sticky protocol-error flag
//
// Option      : PROG_LOADER_OPCODE_CHECK_EN - when defined, transfers with
//               opcode > OPC_MAX are consumed but not written, and set err.
//
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DEPTH   = 32,
    parameter int WORD_W  = 20,
    parameter int FIELD_W = 5,
    parameter int OPC_MAX = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic                            in_last_i,
    input  logic [FIELD_W-1:0]              opcode_i,
    input  logic [FIELD_W-1:0]              addr_a_i,
    input  logic [FIELD_W-1:0]              addr_b_i,
    input  logic [FIELD_W-1:0]              addr_w_i,
    output logic [DEPTH-1:0][WORD_W-1:0]    mem_o,
    output logic [$clog2(DEPTH):0]          prog_len_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             ptr_q,   ptr_d;
    logic [PTR_W:0]               len_q,   len_d;
    logic                         err_q,   err_d;
    logic [DEPTH-1:0][WORD_W-1:0] mem_q;

    logic                         w_we;
    logic                         w_op_ok;
    logic [WORD_W-1:0]            w_word;

    // Exact inverse of the decode stage's field slicing.
    assign w_word = {addr_w_i, addr_b_i, addr_a_i, opcode_i};

`ifdef PROG_LOADER_OPCODE_CHECK_EN
    assign w_op_ok = ({1'b0, opcode_i} <= (FIELD_W+1)'(OPC_MAX));
`else
    logic w_unused_opc_max;
    assign w_unused_opc_max = ^OPC_MAX;
    assign w_op_ok          = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        err_d   = err_q;
        w_we    = 1'b0;

        if (start_i) begin
            // start outranks any transfer presented in the same cycle.
            state_d = LOAD;
            ptr_d   = '0;
            len_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid_i) begin
                        if (w_op_ok) begin
                            w_we  = 1'b1;
                            len_d = len_q + 1'b1;
                            // The pointer saturates; the load ends on the
                            // last entry instead of wrapping.
                            if (ptr_q == C_PTR_LAST) begin
                                state_d = DONE;
                            end else begin
                                ptr_d = ptr_q + 1'b1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                        if (in_last_i) begin
                            state_d = DONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (in_valid_i) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Program memory; fully cleared by reset so fetch never sees stale code.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (w_we) begin
            mem_q[ptr_q] <= w_word;
        end
    end

    assign mem_o      = mem_q;
    assign prog_len_o = len_q;
    assign in_ready_o = (state_q == LOAD);
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A cycle-by-cycle vector
//               table covers reset, encoding, restart and error behaviour;
//               hand-written sequences cover the full-depth load, reset in
//               mid-load and the optional opcode check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int DEPTH   = 32;
    localparam int WORD_W  = 20;
    localparam int FIELD_W = 5;

    logic                         clk;
    logic                         rst;
    logic                         start_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic                         in_last_i;
    logic [FIELD_W-1:0]           opcode_i;
    logic [FIELD_W-1:0]           addr_a_i;
    logic [FIELD_W-1:0]           addr_b_i;
    logic [FIELD_W-1:0]           addr_w_i;
    logic [DEPTH-1:0][WORD_W-1:0] mem_o;
    logic [5:0]                   prog_len_o;
    logic                         done_o;
    logic                         err_o;

    int n_cmp;
    int n_bad;

    prog_loader #(
        .DEPTH   (DEPTH),
        .WORD_W  (WORD_W),
        .FIELD_W (FIELD_W),
        .OPC_MAX (15)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_last_i  (in_last_i),
        .opcode_i   (opcode_i),
        .addr_a_i   (addr_a_i),
        .addr_b_i   (addr_b_i),
        .addr_w_i   (addr_w_i),
        .mem_o      (mem_o),
        .prog_len_o (prog_len_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       valid;
        logic       last;
        logic [4:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] w;
        logic       e_ready;
        logic       e_done;
        logic       e_err;
        logic [5:0] e_len;
        int         idx;
        logic [19:0] e_word;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic l,
                         input logic [4:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] w);
        rst        = r;
        start_i    = s;
        in_valid_i = v;
        in_last_i  = l;
        opcode_i   = op;
        addr_a_i   = a;
        addr_b_i   = b;
        addr_w_i   = w;
    endtask

    // Apply inputs for one rising edge, then sample 1 time unit later.
    task automatic step(input logic r, input logic s, input logic v, input logic l,
                        input logic [4:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] w);
        drive(r, s, v, l, op, a, b, w);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic check_state(input string tag, input logic rdy, input logic dn,
                               input logic er, input logic [5:0] len);
        check({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, rdy});
        check({tag, ".done"},  {31'd0, done_o},     {31'd0, dn});
        check({tag, ".err"},   {31'd0, err_o},      {31'd0, er});
        check({tag, ".len"},   {26'd0, prog_len_o}, {26'd0, len});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        //            rst   start valid last  op     a     b     w     rdy   done  err   len  idx  word
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 0, 20'h00000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5, 20'h00000};
        // in_valid while IDLE: ignored, sticky error
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd0, 0, 20'h00000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 0, 20'h00000};
        // single last transfer: {W=4,B=2,A=1,op=3}
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1, 1'b0, 6'd1, 0, 20'h20823};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd1, 1, 20'h00000};
        // restart from DONE, mem kept
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 0, 20'h20823};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd1, 0, 20'h00041};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd2, 1, 20'h00002};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd3, 2, 20'h00003};
        // start with a simultaneous transfer: transfer dropped
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 3, 20'h00000};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd1, 0, 20'h00009};
        // in_valid while DONE: ignored, sticky error
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 6'd1, 1, 20'h00002};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 6'd1, 0, 20'h00009};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1, 20'h00002};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].last,
                 vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].w);
            check_state($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_done,
                        vecs[i].e_err, vecs[i].e_len);
            check($sformatf("vec%0d.mem[%0d]", i, vecs[i].idx),
                  {12'd0, mem_o[vecs[i].idx]}, {12'd0, vecs[i].e_word});
        end

        // ---- Full-depth load: 32 back-to-back transfers, then one extra ----
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 5'd0, 5'd0, 5'd0);
            if (i == DEPTH - 2) check_state("full.pre", 1'b1, 1'b0, 1'b0, 6'd31);
        end
        check_state("full.end", 1'b0, 1'b1, 1'b0, 6'd32);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("full.mem[%0d]", i), {12'd0, mem_o[i]}, 32'(i));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0);
        check_state("full.extra", 1'b0, 1'b1, 1'b1, 6'd32);
        check("full.extra.mem0", {12'd0, mem_o[0]}, 32'd0);

        // ---- Reset asserted during the 6th transfer ----
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 5'(i + 1), 5'd3, 5'd0, 5'd0);
        end
        check_state("rstmid.pre", 1'b1, 1'b0, 1'b0, 6'd5);
        check("rstmid.pre.mem4", {12'd0, mem_o[4]}, 32'h00065);
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 5'd3, 5'd0, 5'd0);
        check_state("rstmid.post", 1'b0, 1'b0, 1'b0, 6'd0);
        check("rstmid.post.mem_all", {31'd0, (mem_o != '0)}, 32'd0);

        // ---- Opcode above OPC_MAX ----
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 5'd0, 5'd0, 5'd0);
`ifdef PROG_LOADER_OPCODE_CHECK_EN
        check_state("opc", 1'b1, 1'b0, 1'b1, 6'd0);
        check("opc.mem0", {12'd0, mem_o[0]}, 32'h00000);
`else
        check_state("opc", 1'b1, 1'b0, 1'b0, 6'd1);
        check("opc.mem0", {12'd0, mem_o[0]}, 32'h00010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
